// File: rtl/y86_pkg.sv
// Shared Y86 definitions for the memory stage: instruction codes, data word
// width and the memory-access controller state encoding.
package y86_pkg;

    localparam int WORD_W = 64;

    localparam logic [3:0] IHALT   = 4'd0;
    localparam logic [3:0] INOP    = 4'd1;
    localparam logic [3:0] IRRMOVQ = 4'd2;
    localparam logic [3:0] IIRMOVQ = 4'd3;
    localparam logic [3:0] IRMMOVQ = 4'd4;
    localparam logic [3:0] IMRMOVQ = 4'd5;
    localparam logic [3:0] IOPQ    = 4'd6;
    localparam logic [3:0] IJXX    = 4'd7;
    localparam logic [3:0] ICALL   = 4'd8;
    localparam logic [3:0] IRET    = 4'd9;
    localparam logic [3:0] IPUSHQ  = 4'd10;
    localparam logic [3:0] IPOPQ   = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_t;

endpackage

// File: rtl/mem_access_ctrl_mem_op_decode.sv
// mem_op_decode: maps an M-stage icode and its operands to the memory access
// it needs (direction, word address, write data). Purely combinational.
import y86_pkg::*;

module mem_op_decode (
    input  logic [3:0]        icode,
    input  logic [WORD_W-1:0] vale,
    input  logic [WORD_W-1:0] vala,
    input  logic [WORD_W-1:0] valp,
    output logic              is_mem,
    output logic              is_write,
    output logic [WORD_W-1:0] addr,
    output logic [WORD_W-1:0] wdata
);

    // Reads leave wdata at zero so the request bus carries no stale data.
    always_comb begin
        is_mem   = 1'b0;
        is_write = 1'b0;
        addr     = '0;
        wdata    = '0;
        case (icode)
            IMRMOVQ: begin
                is_mem = 1'b1;
                addr   = vale;
            end
            IRET, IPOPQ: begin
                is_mem = 1'b1;
                addr   = vala;
            end
            IRMMOVQ, IPUSHQ: begin
                is_mem   = 1'b1;
                is_write = 1'b1;
                addr     = vale;
                wdata    = vala;
            end
            ICALL: begin
                is_mem   = 1'b1;
                is_write = 1'b1;
                addr     = vale;
                wdata    = valp;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: Y86 memory-stage initiator. Issues one read or write per
// M-stage instruction over a valid/ready request / valid response bus,
// returns val_m and dmem_error with a one-cycle done pulse, and stalls the
// pipeline while the access is outstanding.
// Optional build macro MEM_TIMEOUT_EN adds a REQ+WAIT watchdog.
//
//   state | meaning
//   IDLE  | waiting for an M-stage instruction; the only accepting state
//   REQ   | req_valid high, request fields held until req_ready
//   WAIT  | request taken, waiting for rsp_valid
//   DONE  | done pulse; val_m / dmem_error valid
import y86_pkg::*;

module mem_access_ctrl #(
    parameter int          ADDR_W         = 64,
    parameter int          MEM_WORDS      = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m_valid,
    input  logic [3:0]        m_icode,
    input  logic [WORD_W-1:0] m_vale,
    input  logic [WORD_W-1:0] m_vala,
    input  logic [WORD_W-1:0] m_valp,
    output logic              m_stall,
    output logic              done,
    output logic [WORD_W-1:0] val_m,
    output logic              dmem_error,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_write,
    output logic [ADDR_W-1:0] req_addr,
    output logic [WORD_W-1:0] req_wdata,
    input  logic              rsp_valid,
    input  logic [WORD_W-1:0] rsp_rdata,
    input  logic              rsp_err
);

    mem_state_t        state;
    logic              dec_is_mem;
    logic              dec_is_write;
    logic [WORD_W-1:0] dec_addr;
    logic [WORD_W-1:0] dec_wdata;
    logic              accept;
    logic              in_range;
    logic              tmo_hit;

    mem_op_decode u_decode (
        .icode    (m_icode),
        .vale     (m_vale),
        .vala     (m_vala),
        .valp     (m_valp),
        .is_mem   (dec_is_mem),
        .is_write (dec_is_write),
        .addr     (dec_addr),
        .wdata    (dec_wdata)
    );

    assign accept    = (state == IDLE) && m_valid;
    assign in_range  = dec_addr < 64'(MEM_WORDS);
    assign req_valid = (state == REQ);
    assign done      = (state == DONE);
    assign m_stall   = (state != IDLE) || (m_valid && dec_is_mem);

`ifdef MEM_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    assign tmo_hit = ((state == REQ) || (state == WAIT))
                   && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

    // Watchdog: cycles spent in REQ plus WAIT since the last accept.
    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if ((state == REQ) || (state == WAIT)) begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Access sequencing; result registers only change on accept, response
    // or timeout so they hold through DONE and the following IDLE cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            val_m      <= '0;
            dmem_error <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_write  <= 1'b0;
        end else if (tmo_hit) begin
            state      <= DONE;
            val_m      <= '0;
            dmem_error <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        val_m <= '0;
                        if (dec_is_mem) begin
                            req_addr   <= dec_addr[ADDR_W-1:0];
                            req_wdata  <= dec_wdata;
                            req_write  <= dec_is_write;
                            dmem_error <= !in_range;
                            state      <= in_range ? REQ : DONE;
                        end else begin
                            dmem_error <= 1'b0;
                            state      <= DONE;
                        end
                    end
                end
                REQ: begin
                    if (req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (rsp_valid) begin
                        if (!req_write) begin
                            val_m <= rsp_rdata;
                        end
                        dmem_error <= rsp_err;
                        state      <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: table of instruction vectors driven through
// a bench-side memory responder, expected results queued at issue and popped
// at done, plus hand-written sequences for handshake, stale-response, reset
// and watchdog corner cases.
module tb_mem_access_ctrl;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TMO = 8;
`else
    localparam int unsigned TMO = 255;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        m_valid = 1'b0;
    logic [3:0]  m_icode = 4'd0;
    logic [63:0] m_vale = '0;
    logic [63:0] m_vala = '0;
    logic [63:0] m_valp = '0;
    logic        m_stall;
    logic        done;
    logic [63:0] val_m;
    logic        dmem_error;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid = 1'b0;
    logic [63:0] rsp_rdata = '0;
    logic        rsp_err = 1'b0;

    mem_access_ctrl #(
        .ADDR_W         (64),
        .MEM_WORDS      (1024),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .m_valid    (m_valid),
        .m_icode    (m_icode),
        .m_vale     (m_vale),
        .m_vala     (m_vala),
        .m_valp     (m_valp),
        .m_stall    (m_stall),
        .done       (done),
        .val_m      (val_m),
        .dmem_error (dmem_error),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  icode;
        logic [63:0] vale;
        logic [63:0] vala;
        logic [63:0] valp;
        int          rdy_dly;
        int          rsp_dly;
        logic [63:0] rdata;
        logic        rerr;
        logic        exp_mem;
        logic        exp_req;
        logic        exp_write;
        logic [63:0] exp_addr;
        logic [63:0] exp_wdata;
        logic [63:0] exp_val;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [63:0] val;
        logic        err;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_done(output int waited);
        waited = 0;
        while (!done && waited < 50) begin
            @(negedge clock);
            waited++;
        end
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        chk({tag, "_done"}, done, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_val_m"}, val_m, e.val);
            chk({tag, "_err"}, dmem_error, e.err);
        end
    endtask

    task automatic run_op(input vec_t v);
        int   lat;
        int   w;
        exp_t e;
        @(negedge clock);
        m_valid = 1'b1;
        m_icode = v.icode;
        m_vale  = v.vale;
        m_vala  = v.vala;
        m_valp  = v.valp;
        #1;
        chk("stall_accept", m_stall, v.exp_mem);
        e.val = v.exp_val;
        e.err = v.exp_err;
        sb.push_back(e);
        @(negedge clock);
        m_valid = 1'b0;
        lat = 1;
        if (v.exp_req) begin
            chk("stall_req", m_stall, 1);
            for (int k = 0; k <= v.rdy_dly; k++) begin
                chk("req_valid", req_valid, 1);
                chk("req_addr", req_addr, v.exp_addr);
                chk("req_wdata", req_wdata, v.exp_wdata);
                chk("req_write", req_write, v.exp_write);
                if (k < v.rdy_dly) begin
                    @(negedge clock);
                    lat++;
                end
            end
            req_ready = 1'b1;
            @(negedge clock);
            lat++;
            req_ready = 1'b0;
            chk("req_drop", req_valid, 0);
            chk("stall_wait", m_stall, 1);
            for (int k = 0; k < v.rsp_dly; k++) begin
                @(negedge clock);
                lat++;
            end
            rsp_valid = 1'b1;
            rsp_rdata = v.rdata;
            rsp_err   = v.rerr;
            @(negedge clock);
            lat++;
            rsp_valid = 1'b0;
            rsp_err   = 1'b0;
        end else begin
            chk("no_req", req_valid, 0);
        end
        wait_done(w);
        lat += w;
        chk("latency", lat, v.exp_req ? 3 + v.rdy_dly + v.rsp_dly : 1);
        check_result("vec");
        @(negedge clock);
        chk("done_pulse", done, 0);
        chk("val_hold", val_m, v.exp_val);
        chk("idle_stall", m_stall, 0);
    endtask

    initial begin
        int w;
        int reqs;
        exp_t e;

        //          icode  vale                vala       valp      rdy rsp rdata      rerr mem req wr  addr      wdata     val        err
        vecs[0] = '{4'd5,  64'd7,              64'd0,     64'd0,    0,  0,  64'h77,    0,   1,  1,  0,  64'd7,    64'd0,    64'h77,    0};
        vecs[1] = '{4'd8,  64'd12,             64'd5,     64'h40,   3,  0,  64'h99,    0,   1,  1,  1,  64'd12,   64'h40,   64'd0,     0};
        vecs[2] = '{4'd11, 64'd4,              64'd3,     64'd0,    0,  0,  64'h1234,  0,   1,  1,  0,  64'd3,    64'd0,    64'h1234,  0};
        vecs[3] = '{4'd6,  64'd9,              64'd9,     64'd9,    0,  0,  64'd0,     0,   0,  0,  0,  64'd0,    64'd0,    64'd0,     0};
        vecs[4] = '{4'd4,  64'd1024,           64'd1,     64'd0,    0,  0,  64'd0,     0,   1,  0,  0,  64'd0,    64'd0,    64'd0,     1};
        vecs[5] = '{4'd9,  64'd5,              64'd1023,  64'd0,    1,  2,  64'hdead,  1,   1,  1,  0,  64'd1023, 64'd0,    64'hdead,  1};
        vecs[6] = '{4'd10, 64'h10,             64'habc,   64'd0,    0,  1,  64'h5,     0,   1,  1,  1,  64'h10,   64'habc,  64'd0,     0};
        vecs[7] = '{4'd5,  64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0,   0,  0,  64'd0,     0,   1,  0,  0,  64'd0,    64'd0,    64'd0,     1};
        vecs[8] = '{4'd0,  64'd0,              64'd0,     64'd0,    0,  0,  64'd0,     0,   0,  0,  0,  64'd0,    64'd0,    64'd0,     0};

        repeat (2) @(negedge clock);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", dmem_error, 0);
        chk("rst_stall", m_stall, 0);
        chk("rst_val_m", val_m, 0);
        chk("rst_addr", req_addr, 0);
        chk("rst_wdata", req_wdata, 0);
        chk("rst_write", req_write, 0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i]);
        end

        // A response coinciding with the request handshake must be ignored.
        @(negedge clock);
        m_valid = 1'b1; m_icode = 4'd5; m_vale = 64'd20;
        e.val = 64'h55; e.err = 1'b0;
        sb.push_back(e);
        @(negedge clock);
        m_valid = 1'b0;
        req_ready = 1'b1; rsp_valid = 1'b1; rsp_rdata = 64'hbad; rsp_err = 1'b1;
        @(negedge clock);
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0;
        chk("hs_rsp_ignored", done, 0);
        chk("hs_wait_stall", m_stall, 1);
        @(negedge clock);
        chk("hs_still_wait", done, 0);
        rsp_valid = 1'b1; rsp_rdata = 64'h55;
        @(negedge clock);
        rsp_valid = 1'b0;
        check_result("hs");

        // Stale response while IDLE: no completion, results unchanged.
        @(negedge clock);
        rsp_valid = 1'b1; rsp_rdata = 64'hee; rsp_err = 1'b1;
        @(negedge clock);
        rsp_valid = 1'b0; rsp_err = 1'b0;
        chk("idle_rsp_done", done, 0);
        chk("idle_rsp_val", val_m, 64'h55);
        chk("idle_rsp_err", dmem_error, 0);
        chk("idle_rsp_req", req_valid, 0);

        // Reset while WAIT, then a late response that must be ignored.
        m_valid = 1'b1; m_icode = 4'd11; m_vala = 64'd9;
        @(negedge clock);
        m_valid = 1'b0;
        req_ready = 1'b1;
        @(negedge clock);
        req_ready = 1'b0;
        chk("rw_in_wait", req_valid, 0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rw_req_valid", req_valid, 0);
        chk("rw_done", done, 0);
        chk("rw_stall", m_stall, 0);
        chk("rw_val_m", val_m, 0);
        rsp_valid = 1'b1; rsp_rdata = 64'h42;
        @(negedge clock);
        rsp_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("rw_late_done", done, 0);
            chk("rw_late_val", val_m, 0);
            @(negedge clock);
        end

`ifdef MEM_TIMEOUT_EN
        // Request never accepted: watchdog ends it after TMO cycles in REQ.
        m_valid = 1'b1; m_icode = 4'd5; m_vale = 64'd5;
        e.val = 64'd0; e.err = 1'b1;
        sb.push_back(e);
        @(negedge clock);
        m_valid = 1'b0;
        reqs = 0;
        while (req_valid && reqs < 3 * TMO) begin
            reqs++;
            @(negedge clock);
        end
        chk("tmo_req_cycles", reqs, TMO);
        wait_done(w);
        check_result("tmo");
        @(negedge clock);
        rsp_valid = 1'b1; rsp_rdata = 64'h66;
        @(negedge clock);
        rsp_valid = 1'b0;
        chk("tmo_late_done", done, 0);
        chk("tmo_late_val", val_m, 0);
`else
        reqs = 0;
        w = 0;
`endif

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
